// File: rtl/mem1_pkg.sv
// Shared defaults and encodings for the N-lane MEM1 stage.
package mem1_pkg;

  localparam int LANES_DEF   = 2;
  localparam int BUS_WD_DEF  = 160;
  localparam int FWD_LSB_DEF = 32;
  localparam int FWD_WD_DEF  = 38;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } mem_size_e;

endpackage

// File: rtl/mem1_stage_nlane_prio_enc_lsb.sv
// Lowest-set-bit priority encoder: returns a one-hot grant and its binary index.
module prio_enc_lsb #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req_i,
  output logic [N-1:0]  onehot_o,
  output logic [IW-1:0] idx_o
);

  logic found_s;

  // Scan upward; the first set bit wins.
  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    found_s  = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (req_i[i] && !found_s) begin
        onehot_o[i] = 1'b1;
        idx_o       = IW'(i);
        found_s     = 1'b1;
      end else begin
        found_s     = found_s;
      end
    end
  end

endmodule

// File: rtl/mem1_stage_nlane.sv
// MEM1 stage: holds a LANES-wide bundle and issues its data-SRAM requests in lane order
// over one req/addr_ok port, forwarding the bundle once every surviving request is accepted.
module mem1_stage_nlane
  import mem1_pkg::*;
#(
  parameter int LANES   = LANES_DEF,
  parameter int BUS_WD  = BUS_WD_DEF,
  parameter int FWD_LSB = FWD_LSB_DEF,
  parameter int FWD_WD  = FWD_WD_DEF
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [LANES-1:0]            es_valid,
  input  logic [LANES*BUS_WD-1:0]     es_bus,
  input  logic [LANES-1:0]            es_mem_req,
  input  logic [LANES-1:0]            es_mem_wr,
  input  logic [LANES-1:0]            es_mem_uncache,
  input  logic [LANES-1:0]            es_ex,
  input  logic [2*LANES-1:0]          es_mem_size,
  input  logic [4*LANES-1:0]          es_mem_wstrb,
  input  logic [32*LANES-1:0]         es_mem_addr,
  input  logic [32*LANES-1:0]         es_mem_wdata,
  output logic                        m1s_allowin,
  output logic                        m1s_ex,
  input  logic                        m2s_allowin,
  input  logic                        m2s_flush,
  input  logic                        ex_taken,
  input  logic                        eret_taken,
  input  logic                        m1s_stall,
  output logic [LANES-1:0]            m1s_to_m2s_valid,
  output logic [LANES*BUS_WD-1:0]     m1s_to_m2s_bus,
  output logic [LANES-1:0]            m1s_req_issued,
  output logic [LANES*(FWD_WD+1)-1:0] m1s_fwd_bus,
  output logic [LANES-1:0]            m1s_valid,
  output logic                        m1s_ready_go,
  output logic                        data_sram_req,
  output logic                        data_sram_wr,
  output logic [1:0]                  data_sram_size,
  output logic [3:0]                  data_sram_wstrb,
  output logic [31:0]                 data_sram_addr,
  output logic [31:0]                 data_sram_wdata,
  input  logic                        data_sram_addr_ok,
  output logic                        data_uncache
);

  localparam int IW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int FE = FWD_WD + 1;

  logic [LANES-1:0]             valid_q, valid_d;
  logic [LANES-1:0]             pending_q, pending_d;
  logic [LANES-1:0]             issued_q, issued_d;
  logic [LANES-1:0][BUS_WD-1:0] bus_q, bus_d;
  logic [LANES-1:0][FE-1:0]     fwd_q, fwd_d;
  logic [LANES-1:0]             wr_q, wr_d;
  logic [LANES-1:0]             unc_q, unc_d;
  logic [LANES-1:0]             ex_q, ex_d;
  logic [LANES-1:0][1:0]        size_q, size_d;
  logic [LANES-1:0][3:0]        wstrb_q, wstrb_d;
  logic [LANES-1:0][31:0]       addr_q, addr_d;
  logic [LANES-1:0][31:0]       wdata_q, wdata_d;

  logic             cancel_s;
  logic             req_s;
  logic             hs_s;
  logic             ex_seen_s;
  logic [LANES-1:0] cur_oh_s;
  logic [IW-1:0]    cur_idx_s;

  prio_enc_lsb #(
    .N  (LANES),
    .IW (IW)
  ) u_prio (
    .req_i    (pending_q),
    .onehot_o (cur_oh_s),
    .idx_o    (cur_idx_s)
  );

  assign cancel_s = ex_taken | eret_taken;
  assign req_s    = (|pending_q) & ~m1s_stall & ~cancel_s;
  assign hs_s     = req_s & data_sram_addr_ok;

  // Last request finishing this cycle also lets the bundle go.
  assign m1s_ready_go = ~(|valid_q) |
                        (~m1s_stall & ((pending_q == '0) |
                                       ((pending_q == cur_oh_s) & hs_s)));
  assign m1s_allowin  = ~(|valid_q) | (m1s_ready_go & m2s_allowin);

  assign m1s_valid        = valid_q;
  assign m1s_ex           = |(ex_q & valid_q);
  assign m1s_to_m2s_valid = valid_q & {LANES{m1s_ready_go & ~m2s_flush}};
  assign m1s_to_m2s_bus   = bus_q;
  assign m1s_fwd_bus      = fwd_q;
  assign m1s_req_issued   = issued_q | (cur_oh_s & {LANES{hs_s}});

  assign data_sram_req   = req_s;
  assign data_sram_wr    = wr_q[cur_idx_s];
  assign data_uncache    = unc_q[cur_idx_s];
  assign data_sram_size  = size_q[cur_idx_s];
  assign data_sram_wstrb = wstrb_q[cur_idx_s];
  assign data_sram_addr  = addr_q[cur_idx_s];
  assign data_sram_wdata = wdata_q[cur_idx_s];

  // Next-state: load wins over cancel, cancel wins over handshake.
  always_comb begin
    valid_d   = valid_q;
    pending_d = pending_q;
    issued_d  = issued_q;
    bus_d     = bus_q;
    fwd_d     = fwd_q;
    wr_d      = wr_q;
    unc_d     = unc_q;
    ex_d      = ex_q;
    size_d    = size_q;
    wstrb_d   = wstrb_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    ex_seen_s = 1'b0;
    if (m1s_allowin) begin
      issued_d = '0;
      for (int i = 0; i < LANES; i++) begin
        // An exception kills its own lane's request and every younger one.
        ex_seen_s    = ex_seen_s | es_ex[i];
        valid_d[i]   = es_valid[i];
        pending_d[i] = es_valid[i] & es_mem_req[i] & ~ex_seen_s & ~cancel_s;
        if (es_valid[i]) begin
          bus_d[i]   = es_bus[i*BUS_WD +: BUS_WD];
          fwd_d[i]   = {1'b1, es_bus[i*BUS_WD+FWD_LSB +: FWD_WD]};
          wr_d[i]    = es_mem_wr[i];
          unc_d[i]   = es_mem_uncache[i];
          ex_d[i]    = es_ex[i];
          size_d[i]  = es_mem_size[i*2 +: 2];
          wstrb_d[i] = es_mem_wstrb[i*4 +: 4];
          addr_d[i]  = es_mem_addr[i*32 +: 32];
          wdata_d[i] = es_mem_wdata[i*32 +: 32];
        end else begin
          bus_d[i]   = '0;
          fwd_d[i]   = '0;
          wr_d[i]    = 1'b0;
          unc_d[i]   = 1'b0;
          ex_d[i]    = 1'b0;
          size_d[i]  = 2'd0;
          wstrb_d[i] = 4'd0;
          addr_d[i]  = 32'd0;
          wdata_d[i] = 32'd0;
        end
      end
    end else if (cancel_s) begin
      valid_d   = '0;
      pending_d = '0;
      issued_d  = '0;
      fwd_d     = '0;
    end else if (hs_s) begin
      pending_d = pending_q & ~cur_oh_s;
      issued_d  = issued_q | cur_oh_s;
    end else begin
      pending_d = pending_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q   <= '0;
      pending_q <= '0;
      issued_q  <= '0;
      bus_q     <= '0;
      fwd_q     <= '0;
      wr_q      <= '0;
      unc_q     <= '0;
      ex_q      <= '0;
      size_q    <= '0;
      wstrb_q   <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      valid_q   <= valid_d;
      pending_q <= pending_d;
      issued_q  <= issued_d;
      bus_q     <= bus_d;
      fwd_q     <= fwd_d;
      wr_q      <= wr_d;
      unc_q     <= unc_d;
      ex_q      <= ex_d;
      size_q    <= size_d;
      wstrb_q   <= wstrb_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
    end
  end

endmodule

// File: tb/tb_mem1_stage_nlane.sv
// Directed bench for mem1_stage_nlane (LANES=2) with hand-computed expectations.
module tb_mem1_stage_nlane;

  localparam int L  = 2;
  localparam int BW = 160;
  localparam int FW = 38;

  logic              clk = 1'b0;
  logic              reset;
  logic [L-1:0]      es_valid, es_mem_req, es_mem_wr, es_mem_uncache, es_ex;
  logic [L*BW-1:0]   es_bus;
  logic [2*L-1:0]    es_mem_size;
  logic [4*L-1:0]    es_mem_wstrb;
  logic [32*L-1:0]   es_mem_addr, es_mem_wdata;
  logic              m1s_allowin, m1s_ex, m2s_allowin, m2s_flush;
  logic              ex_taken, eret_taken, m1s_stall;
  logic [L-1:0]      m1s_to_m2s_valid, m1s_req_issued, m1s_valid;
  logic [L*BW-1:0]   m1s_to_m2s_bus;
  logic [L*(FW+1)-1:0] m1s_fwd_bus;
  logic              m1s_ready_go;
  logic              data_sram_req, data_sram_wr, data_sram_addr_ok, data_uncache;
  logic [1:0]        data_sram_size;
  logic [3:0]        data_sram_wstrb;
  logic [31:0]       data_sram_addr, data_sram_wdata;

  int checks = 0;
  int errors = 0;

  logic [BW-1:0] p1;

  mem1_stage_nlane dut (
    .clk               (clk),
    .reset             (reset),
    .es_valid          (es_valid),
    .es_bus            (es_bus),
    .es_mem_req        (es_mem_req),
    .es_mem_wr         (es_mem_wr),
    .es_mem_uncache    (es_mem_uncache),
    .es_ex             (es_ex),
    .es_mem_size       (es_mem_size),
    .es_mem_wstrb      (es_mem_wstrb),
    .es_mem_addr       (es_mem_addr),
    .es_mem_wdata      (es_mem_wdata),
    .m1s_allowin       (m1s_allowin),
    .m1s_ex            (m1s_ex),
    .m2s_allowin       (m2s_allowin),
    .m2s_flush         (m2s_flush),
    .ex_taken          (ex_taken),
    .eret_taken        (eret_taken),
    .m1s_stall         (m1s_stall),
    .m1s_to_m2s_valid  (m1s_to_m2s_valid),
    .m1s_to_m2s_bus    (m1s_to_m2s_bus),
    .m1s_req_issued    (m1s_req_issued),
    .m1s_fwd_bus       (m1s_fwd_bus),
    .m1s_valid         (m1s_valid),
    .m1s_ready_go      (m1s_ready_go),
    .data_sram_req     (data_sram_req),
    .data_sram_wr      (data_sram_wr),
    .data_sram_size    (data_sram_size),
    .data_sram_wstrb   (data_sram_wstrb),
    .data_sram_addr    (data_sram_addr),
    .data_sram_wdata   (data_sram_wdata),
    .data_sram_addr_ok (data_sram_addr_ok),
    .data_uncache      (data_uncache)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_es();
    es_valid       = '0;
    es_mem_req     = '0;
    es_mem_wr      = '0;
    es_mem_uncache = '0;
    es_ex          = '0;
  endtask

  initial begin
    reset = 1'b1;
    clear_es();
    es_bus = '0; es_mem_size = '0; es_mem_wstrb = '0; es_mem_addr = '0; es_mem_wdata = '0;
    m2s_allowin = 1'b1; m2s_flush = 1'b0; ex_taken = 1'b0; eret_taken = 1'b0;
    m1s_stall = 1'b0; data_sram_addr_ok = 1'b0;
    p1 = {90'h0, 38'h3A_BCDE_F012, 32'hFFFF_FFFF};
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("rst_valid", m1s_valid, 2'b00);
    chk("rst_req", data_sram_req, 1'b0);
    chk("rst_ready_go", m1s_ready_go, 1'b1);
    chk("rst_allowin", m1s_allowin, 1'b1);
    chk("rst_to_m2s", m1s_to_m2s_valid, 2'b00);
    chk("rst_fwd", m1s_fwd_bus, 78'h0);

    // lane1 uncached store only
    es_valid = 2'b10; es_mem_req = 2'b10; es_mem_wr = 2'b10; es_mem_uncache = 2'b10;
    es_mem_size = 4'b1000; es_mem_wstrb = 8'hF0;
    es_mem_addr = {32'h8000_0010, 32'h0}; es_mem_wdata = {32'hDEAD_BEEF, 32'h0};
    es_bus = {p1, 160'h0}; data_sram_addr_ok = 1'b1;
    tick(); clear_es(); #1;
    chk("st_valid", m1s_valid, 2'b10);
    chk("st_req", data_sram_req, 1'b1);
    chk("st_wr", data_sram_wr, 1'b1);
    chk("st_unc", data_uncache, 1'b1);
    chk("st_addr", data_sram_addr, 32'h8000_0010);
    chk("st_wstrb", data_sram_wstrb, 4'hF);
    chk("st_size", data_sram_size, 2'd2);
    chk("st_wdata", data_sram_wdata, 32'hDEAD_BEEF);
    chk("st_ready_go", m1s_ready_go, 1'b1);
    chk("st_to_m2s", m1s_to_m2s_valid, 2'b10);
    chk("st_issued", m1s_req_issued, 2'b10);
    chk("st_allowin", m1s_allowin, 1'b1);
    chk("st_fwd", m1s_fwd_bus, {1'b1, 38'h3A_BCDE_F012, 39'h0});
    chk("st_bus", m1s_to_m2s_bus, {p1, 160'h0});
    chk("st_ex", m1s_ex, 1'b0);
    tick();
    chk("st_gone_valid", m1s_valid, 2'b00);
    chk("st_gone_req", data_sram_req, 1'b0);
    chk("st_gone_fwd", m1s_fwd_bus, 78'h0);

    // two loads, addr_ok every cycle
    es_valid = 2'b11; es_mem_req = 2'b11; es_mem_size = 4'b1010; es_mem_wstrb = 8'h00;
    es_mem_addr = {32'h200, 32'h100}; es_bus = '0;
    tick(); clear_es(); #1;
    chk("ld2_c0_req", data_sram_req, 1'b1);
    chk("ld2_c0_addr", data_sram_addr, 32'h100);
    chk("ld2_c0_wr", data_sram_wr, 1'b0);
    chk("ld2_c0_ready_go", m1s_ready_go, 1'b0);
    chk("ld2_c0_allowin", m1s_allowin, 1'b0);
    chk("ld2_c0_issued", m1s_req_issued, 2'b01);
    chk("ld2_c0_to_m2s", m1s_to_m2s_valid, 2'b00);
    tick();
    chk("ld2_c1_req", data_sram_req, 1'b1);
    chk("ld2_c1_addr", data_sram_addr, 32'h200);
    chk("ld2_c1_ready_go", m1s_ready_go, 1'b1);
    chk("ld2_c1_allowin", m1s_allowin, 1'b1);
    chk("ld2_c1_issued", m1s_req_issued, 2'b11);
    chk("ld2_c1_to_m2s", m1s_to_m2s_valid, 2'b11);
    tick();
    chk("ld2_gone_valid", m1s_valid, 2'b00);

    // lane0 halfword load, addr_ok held low for three cycles
    es_valid = 2'b01; es_mem_req = 2'b01; es_mem_size = 4'b0001;
    es_mem_addr = {32'h0, 32'h300}; data_sram_addr_ok = 1'b0;
    tick(); clear_es(); #1;
    for (int k = 0; k < 3; k++) begin
      chk("wait_req", data_sram_req, 1'b1);
      chk("wait_addr", data_sram_addr, 32'h300);
      chk("wait_size", data_sram_size, 2'd1);
      chk("wait_ready_go", m1s_ready_go, 1'b0);
      tick();
    end
    data_sram_addr_ok = 1'b1; #1;
    chk("wait_acc_ready_go", m1s_ready_go, 1'b1);
    chk("wait_acc_issued", m1s_req_issued, 2'b01);
    chk("wait_acc_addr", data_sram_addr, 32'h300);
    tick();
    chk("wait_gone_valid", m1s_valid, 2'b00);

    // lane0 exception kills both requests
    es_valid = 2'b11; es_mem_req = 2'b11; es_ex = 2'b01;
    tick(); clear_es(); #1;
    chk("exc_req", data_sram_req, 1'b0);
    chk("exc_m1s_ex", m1s_ex, 1'b1);
    chk("exc_ready_go", m1s_ready_go, 1'b1);
    chk("exc_to_m2s", m1s_to_m2s_valid, 2'b11);
    chk("exc_issued", m1s_req_issued, 2'b00);
    tick();
    chk("exc_gone_valid", m1s_valid, 2'b00);
    chk("exc_gone_ex", m1s_ex, 1'b0);

    // eret while lane1 still pending
    es_valid = 2'b11; es_mem_req = 2'b11; es_mem_size = 4'b1010; es_mem_addr = {32'h200, 32'h100};
    tick(); clear_es(); #1;
    chk("eret_c0_addr", data_sram_addr, 32'h100);
    tick();
    eret_taken = 1'b1; #1;
    chk("eret_req", data_sram_req, 1'b0);
    chk("eret_ready_go", m1s_ready_go, 1'b0);
    chk("eret_to_m2s", m1s_to_m2s_valid, 2'b00);
    tick();
    eret_taken = 1'b0; #1;
    chk("eret_after_valid", m1s_valid, 2'b00);
    chk("eret_after_req", data_sram_req, 1'b0);
    chk("eret_after_allowin", m1s_allowin, 1'b1);
    tick();
    chk("eret_later_req", data_sram_req, 1'b0);

    // full stage, MEM2 not accepting, flush gating
    es_valid = 2'b01; m2s_allowin = 1'b0; m2s_flush = 1'b1;
    tick(); clear_es(); #1;
    chk("hold_valid", m1s_valid, 2'b01);
    chk("hold_ready_go", m1s_ready_go, 1'b1);
    chk("hold_allowin", m1s_allowin, 1'b0);
    chk("hold_flush_to_m2s", m1s_to_m2s_valid, 2'b00);
    chk("hold_req", data_sram_req, 1'b0);
    tick();
    chk("hold_valid2", m1s_valid, 2'b01);
    m2s_flush = 1'b0; #1;
    chk("hold_to_m2s", m1s_to_m2s_valid, 2'b01);
    m2s_allowin = 1'b1;
    tick();
    chk("hold_gone_valid", m1s_valid, 2'b00);

    // stall withdraws request, then reset mid-issue
    es_valid = 2'b11; es_mem_req = 2'b11; data_sram_addr_ok = 1'b0;
    tick(); clear_es(); #1;
    chk("stall_pre_req", data_sram_req, 1'b1);
    m1s_stall = 1'b1; #1;
    chk("stall_req", data_sram_req, 1'b0);
    chk("stall_ready_go", m1s_ready_go, 1'b0);
    m1s_stall = 1'b0; reset = 1'b1; #1;
    chk("prerst_req", data_sram_req, 1'b1);
    tick();
    reset = 1'b0; #1;
    chk("midrst_req", data_sram_req, 1'b0);
    chk("midrst_valid", m1s_valid, 2'b00);
    chk("midrst_fwd", m1s_fwd_bus, 78'h0);
    chk("midrst_ready_go", m1s_ready_go, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
